// File: rtl/enable_sequencer.sv
// enable_sequencer
//   Start-up sequencer. Once the level enable has been held for DelayCycles
//   cycles it issues a one-cycle start pulse, then holds ready and emits a
//   periodic tick every TickPeriod cycles until the enable drops.
//
// Parameters
//   DelayCycles : cycles en must be held before start (1..65535)
//   TickPeriod  : tick period while running, in cycles (2..65535)
//
// Ports
//   clock : single clock, rising edge
//   reset : synchronous, active-high
//   en    : level enable, sampled every edge
//   start : one-cycle pulse when the delay completes
//   ready : high while running
//   tick  : one-cycle pulse every TickPeriod cycles while running
//   busy  : high while delaying or pulsing start
module enable_sequencer #(
    parameter int unsigned DelayCycles = 16,
    parameter int unsigned TickPeriod  = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic en,
    output logic start,
    output logic ready,
    output logic tick,
    output logic busy
);

    localparam int unsigned CntMax = (DelayCycles > TickPeriod) ? DelayCycles : TickPeriod;
    localparam int unsigned CntW   = (CntMax > 1) ? $clog2(CntMax) : 1;

    localparam logic [CntW-1:0] DelayLast = CntW'(DelayCycles - 1);
    localparam logic [CntW-1:0] TickLast  = CntW'(TickPeriod - 1);

    typedef enum logic [1:0] {
        StIdle,
        StDelay,
        StPulse,
        StRun
    } state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              tick_d;

    // One counter is shared: it measures the enable hold time in DELAY and
    // the tick phase in RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d = StDelay;
                    cnt_d   = '0;
                end
            end
            StDelay: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == DelayLast) begin
                    state_d = StPulse;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            // en is deliberately ignored here so start is always one full cycle.
            StPulse: begin
                state_d = StRun;
                cnt_d   = '0;
            end
            StRun: begin
                if (!en) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == TickLast) begin
                    cnt_d  = '0;
                    tick_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state decode, so they line up
    // with the state register and never depend combinationally on en.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            start   <= 1'b0;
            ready   <= 1'b0;
            tick    <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            start   <= (state_d == StPulse);
            ready   <= (state_d == StRun);
            tick    <= tick_d;
            busy    <= (state_d == StDelay) || (state_d == StPulse);
        end
    end

endmodule

// File: tb/tb_enable_sequencer.sv
// Bench for enable_sequencer. Two instances (16/8 and the 1/2 boundary) share
// clock, reset and en. The reference model tracks only the number of edges
// since the enable was first seen in idle and derives every output from that.
module tb_enable_sequencer;

    localparam int DA = 16;
    localparam int PA = 8;
    localparam int DB = 1;
    localparam int PB = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic en    = 1'b0;

    logic start_a, ready_a, tick_a, busy_a;
    logic start_b, ready_b, tick_b, busy_b;

    int total = 0;
    int bad   = 0;

    // Edges since E0 for each instance; -1 means idle.
    int t_a = -1;
    int t_b = -1;

    always #5 clock = ~clock;

    enable_sequencer #(
        .DelayCycles(DA),
        .TickPeriod (PA)
    ) dut_a (
        .clock(clock),
        .reset(reset),
        .en   (en),
        .start(start_a),
        .ready(ready_a),
        .tick (tick_a),
        .busy (busy_a)
    );

    enable_sequencer #(
        .DelayCycles(DB),
        .TickPeriod (PB)
    ) dut_b (
        .clock(clock),
        .reset(reset),
        .en   (en),
        .start(start_b),
        .ready(ready_b),
        .tick (tick_b),
        .busy (busy_b)
    );

    function automatic int next_t(input int t, input logic e, input logic r, input int d);
        if (r) return -1;
        if (t < 0) return e ? 0 : -1;
        if (t == d) return d + 1;
        if (!e) return -1;
        return t + 1;
    endfunction

    // Expected {start, ready, tick, busy} after the edge that produced t.
    function automatic logic [3:0] model_out(input int t, input int d, input int p);
        logic s, rdy, tk, b;
        s   = (t == d);
        rdy = (t > d);
        tk  = (t >= d + 1 + p) && (((t - d - 1) % p) == 0);
        b   = (t >= 0) && (t <= d);
        return {s, rdy, tk, b};
    endfunction

    task automatic step(input logic e, input logic r);
        en    = e;
        reset = r;
        @(posedge clock);
        t_a = next_t(t_a, e, r, DA);
        t_b = next_t(t_b, e, r, DB);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] exp;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1);
            exp = 8'h00;
            total++;
            if ({start_a, ready_a, tick_a, busy_a, start_b, ready_b, tick_b, busy_b} !== exp) begin
                bad++;
                $display("FAIL reset cyc=%0d got=%b want=%b", i,
                         {start_a, ready_a, tick_a, busy_a, start_b, ready_b, tick_b, busy_b}, exp);
            end
        end
    endtask

    task automatic test_const_en();
        logic [7:0] exp;
        int starts = 0;
        int ticks  = 0;
        step(1'b0, 1'b1);
        for (int i = 0; i < 60; i++) begin
            step(1'b1, 1'b0);
            exp = {model_out(t_a, DA, PA), model_out(t_b, DB, PB)};
            total++;
            if ({start_a, ready_a, tick_a, busy_a, start_b, ready_b, tick_b, busy_b} !== exp) begin
                bad++;
                $display("FAIL const_en t=%0d got=%b want=%b", t_a,
                         {start_a, ready_a, tick_a, busy_a, start_b, ready_b, tick_b, busy_b}, exp);
            end
            if (start_a === 1'b1) starts++;
            if (tick_a === 1'b1) ticks++;
        end
        // Ticks expected at E0+25, 33, 41, 49, 57.
        total++;
        if (starts !== 1 || ticks !== 5) begin
            bad++;
            $display("FAIL const_en_counts starts=%0d ticks=%0d want starts=1 ticks=5",
                     starts, ticks);
        end
    endtask

    task automatic run_pattern(input string name, input logic [1:0] pat[$]);
        logic [7:0] exp;
        foreach (pat[i]) begin
            step(pat[i][0], pat[i][1]);
            exp = {model_out(t_a, DA, PA), model_out(t_b, DB, PB)};
            total++;
            if ({start_a, ready_a, tick_a, busy_a, start_b, ready_b, tick_b, busy_b} !== exp) begin
                bad++;
                $display("FAIL %s cyc=%0d got=%b want=%b", name, i,
                         {start_a, ready_a, tick_a, busy_a, start_b, ready_b, tick_b, busy_b}, exp);
            end
        end
    endtask

    // Patterns are {reset, en} per cycle.
    task automatic test_abort();
        logic [1:0] pat[$];
        pat.push_back(2'b10);
        for (int i = 0; i < 10; i++) pat.push_back(2'b01);
        for (int i = 0; i < 3; i++) pat.push_back(2'b00);
        for (int i = 0; i < 40; i++) pat.push_back(2'b01);
        run_pattern("abort", pat);
    endtask

    task automatic test_run_drop();
        logic [1:0] pat[$];
        pat.push_back(2'b10);
        for (int i = 0; i < 30; i++) pat.push_back(2'b01);
        pat.push_back(2'b00);
        for (int i = 0; i < 45; i++) pat.push_back(2'b01);
        run_pattern("run_drop", pat);
    endtask

    task automatic test_pulse_drop();
        logic [1:0] pat[$];
        pat.push_back(2'b10);
        for (int i = 0; i < DA + 1; i++) pat.push_back(2'b01);
        for (int i = 0; i < 6; i++) pat.push_back(2'b00);
        run_pattern("pulse_drop", pat);
        total++;
        if (ready_a !== 1'b0 || busy_a !== 1'b0 || start_a !== 1'b0) begin
            bad++;
            $display("FAIL pulse_drop_idle ready=%b busy=%b start=%b want 0 0 0",
                     ready_a, busy_a, start_a);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0] pat[$];
        pat.push_back(2'b10);
        for (int i = 0; i < 8; i++) pat.push_back(2'b01);
        pat.push_back(2'b11);
        for (int i = 0; i < 30; i++) pat.push_back(2'b01);
        pat.push_back(2'b11);
        for (int i = 0; i < 30; i++) pat.push_back(2'b01);
        run_pattern("reset_mid", pat);
    endtask

    task automatic test_boundary();
        logic [3:0] seen[8];
        logic [3:0] want[8];
        step(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b0);
            seen[i] = {start_b, ready_b, tick_b, busy_b};
        end
        // {start, ready, tick, busy} after edges E0..E0+7 for DelayCycles=1, TickPeriod=2.
        want = '{4'b0001, 4'b1001, 4'b0100, 4'b0100, 4'b0110, 4'b0100, 4'b0110, 4'b0100};
        for (int i = 0; i < 8; i++) begin
            total++;
            if (seen[i] !== want[i]) begin
                bad++;
                $display("FAIL boundary E0+%0d got=%b want=%b", i, seen[i], want[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [1:0] pat[$];
        logic       e;
        e = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) e = ~e;
            if ($urandom_range(0, 3) == 0 && !e) e = 1'b1;
            pat.push_back({($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, e});
        end
        run_pattern("random", pat);
    endtask

    initial begin
        test_reset();
        test_const_en();
        test_abort();
        test_run_drop();
        test_pulse_drop();
        test_reset_mid();
        test_boundary();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/enable_sequencer.md
# enable_sequencer

Start-up sequencer that consumes a level enable, most often tied to a constant-high terminal, and turns it into a timed power-up sequence. After enable has been held for a programmable delay, the block issues a one-cycle `start` pulse, then holds `ready` and emits a periodic `tick`. It sits directly downstream of the tie-high/tie-low primitives. It gives UDB designs a deterministic "go" event after reset release.

## Interface
- `DelayCycles`, default 16: cycles `en` must be held before `start`; legal range 1..65535.
- `TickPeriod`, default 8: period of `tick` in RUN, in cycles; legal range 2..65535.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: reset is synchronous and active-high.
- `en` input 1: level enable, sampled every edge; typically a constant 1.
- `start` output 1: one-cycle pulse when the delay completes.
- `ready` output 1: high for as long as the block is in RUN.
- `tick` output 1: one-cycle pulse every `TickPeriod` cycles while in RUN.
- `busy` output 1: high in DELAY and PULSE.

## Operation
- States: IDLE, DELAY, PULSE, RUN. All outputs are decoded from registered state and counters only, with no combinational path from `en`.
- Counter width is clog2(max(DelayCycles, TickPeriod)). One shared counter serves DELAY and RUN.
- Counting rule: the counter increments by 1 per cycle and never wraps past its terminal value. At the terminal value it either transitions or reloads to 0.
- Reset: state=IDLE, counter=0. `start`, `ready`, `tick` and `busy` are all 0 in the cycle after the reset edge.
- IDLE:
  - `en`=1 → DELAY, counter=0.
  - Otherwise stay in IDLE.
- DELAY:
  - `en`=0 → IDLE, counter=0. An aborted delay restarts from zero.
  - counter==DelayCycles-1 → PULSE.
  - Otherwise counter+1.
- PULSE:
  - `start`=1 for exactly this state.
  - Always → RUN with counter=0, even if `en`=0 on this edge.
  - `en` is not sampled in PULSE, so `start` is never truncated or repeated.
- RUN:
  - `ready`=1.
  - `en`=0 → IDLE, counter=0.
  - counter==TickPeriod-1 → counter=0 and `tick` asserted for the following cycle.
  - Otherwise counter+1.
- `tick` is a separate register. It is cleared on leaving RUN, so no `tick` is ever seen with `ready`=0.
- Re-enable after a drop in RUN reruns the full sequence: DELAY, then PULSE with a new `start`.
- `en` tied to 1: exactly one `start` per reset release, followed by an endless `tick` train.
- Reset mid-operation (any state) overrides `en` and goes to IDLE on that edge.

## Timing
- Reference edge: E0 is the first edge with `en`=1 sampled in IDLE.
- `busy` rises in the cycle after E0.
- `start` is high in the cycle after edge E0+DelayCycles. Latency from the `en` sample to `start` is DelayCycles+1 cycles.
- `ready` rises in the cycle after E0+DelayCycles+1, which is the cycle after `start`. `busy` falls at the same edge.
- First `tick` is in the cycle after edge E0+DelayCycles+1+TickPeriod. Subsequent ticks follow every TickPeriod cycles exactly.
- `en` falling:
  - Sampled 0 in RUN: `ready` and `tick` are 0 from the next cycle.
  - Sampled 0 in DELAY: `busy` is 0 from the next cycle.
- `start`, `ready` and `tick` are never high in the same cycle as `reset` taking effect.

## Test plan
- Reset then `en`=1 constant, DelayCycles=16, TickPeriod=8 → `start` high for 1 cycle at E0+16, `ready` from E0+17, `tick` at E0+25, E0+33, E0+41; no second `start`.
- `en` pulsed high for 10 cycles, low for 3, then held high (DelayCycles=16) → no `start` during the first pulse; `start` 17 cycles after re-enable.
- Drop `en` for 1 cycle during RUN, then raise it → `ready` and `tick` clear next cycle; full DELAY and `start` are repeated; tick phase restarts.
- `en` falls on the PULSE edge → `start` still a full single cycle, `ready` high for 1 cycle, then IDLE.
- Assert `reset` for 1 cycle mid-DELAY and again mid-RUN with `en`=1 → all outputs 0 next cycle; sequence restarts from E0 after release.
- DelayCycles=1, TickPeriod=2 boundary → `start` at E0+1, `ready` at E0+2, `tick` every 2nd cycle starting at E0+4.
